multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control and sequencing unit for the 16-bit RISC core: fetches instructions, reads the register file, drives the ALU's operand and function-select inputs, consumes its result and zero flag, and performs memory access and register write-back. It is the driving end of the ALU interface. It connects to an external instruction memory, data memory and register file through simple request/acknowledge handshakes.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_req  out  1  instruction fetch request (held until accepted)
- instr_addr  out  16  fetch address = PC
- instr_valid  in  1  instruction word valid this cycle
- instr_in  in  16  instruction word
- rf_raddr1 / rf_raddr2  out  3  register-file read addresses (IR[8:6] / IR[5:3], or IR[11:9] for ST/BEQ/BNE)
- rf_rdata1 / rf_rdata2  in  16  combinational register-file read data
- rf_we  out  1  register write enable (one-cycle pulse)
- rf_waddr  out  3  write address = IR[11:9]
- rf_wdata  out  16  write data
- alu_a / alu_b  out  16  ALU operands
- alu_control  out  3  ALU function select
- alu_result  in  16  ALU result
- alu_zero  in  1  ALU zero flag
- mem_req  out  1  data-memory request (held until mem_ack)
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_addr  out  16  data address
- mem_wdata  out  16  store data
- mem_rdata  in  16  load data, valid with mem_ack
- mem_ack  in  1  data access complete
- halted  out  1  high once HALT executed, until reset

## Operation
- Format: op=IR[15:12], rd=IR[11:9], rs1=IR[8:6], rs2=IR[5:3], imm6=IR[5:0] (sign-extended), imm12=IR[11:0] (sign-extended).
- op 0000–0111: R-type, rd = rs1 OP rs2, alu_control = op[2:0] (000 add, 001 sub, 010 inv, 011 lsl, 100 lsr, 101 and, 110 or, 111 slt).
- 1000 LD: rd = mem[rs1+imm6]. 1001 ST: mem[rs1+imm6] = rd. 1101 ADDI: rd = rs1+imm6. ALU control 000 for all three.
- 1010 BEQ / 1011 BNE: ALU sub on rd vs rs1; taken if alu_zero=1 (BEQ) / 0 (BNE); target = PC+1+imm6.
- 1100 JMP: PC = PC+1+imm12. 1110: NOP. 1111 HALT.
- States: FETCH -> DECODE -> EXECUTE -> {MEM, WRITEBACK, FETCH}; HALTED terminal.
- FETCH: instr_req=1; on instr_valid latch IR, PC <= PC+1, go DECODE. instr_valid outside FETCH ignored.
- DECODE: latch rf_rdata1/2 into A/B. JMP: PC <= PC+imm12, go FETCH. NOP: go FETCH. HALT: go HALTED.
- EXECUTE: alu_a=A, alu_b=B (R-type, branch) or imm6 (LD/ST/ADDI); latch alu_result into ALUOUT. Branch: if taken PC <= PC+imm6; go FETCH. LD/ST -> MEM; R-type/ADDI -> WRITEBACK.
- MEM: mem_req=1, mem_addr=ALUOUT, mem_wdata=B, mem_we per op, all stable until mem_ack. On ack: ST -> FETCH; LD latches mem_rdata into MDR, -> WRITEBACK.
- WRITEBACK: rf_we=1 for exactly one cycle, rf_wdata = MDR (LD) or ALUOUT; go FETCH.
- Outside EXECUTE: alu_control=000, alu_a/alu_b hold A and B.
- All PC/address arithmetic modulo 2^16; 16'hFFFF+1 wraps to 16'h0000; negative offsets wrap likewise.

## Timing
- Reset: PC=RESET_PC, state FETCH, IR=0, instr_req=1 in first post-reset cycle; rf_we, mem_req, mem_we, halted=0; alu_control=000; rf_wdata, mem_addr, mem_wdata, alu_a, alu_b=0.
- rst asserted in any state, including mid-handshake: next cycle in FETCH with reset values; pending mem_req dropped without waiting for mem_ack; no rf_we issued.
- Zero-wait memories (valid/ack same cycle as request): R-type/ADDI 4 cycles, LD 5, ST 4, branch 3, JMP/NOP 2, HALT 2 then HALTED.
- Each wait cycle on instr_valid or mem_ack adds one cycle; outputs held constant while waiting.
- halted rises the cycle after DECODE of HALT; instr_req stays 0 thereafter.

## Test plan
- Reset, then ADD r3,r1,r2 with r1=0x0005, r2=0x0003 -> alu_control=000 in EXECUTE, rf_we pulse with rf_waddr=3, rf_wdata=0x0008, 4 cycles; PC=0x0001.
- LD r4,[r1+2], r1=0x0010, mem_ack delayed 3 cycles, mem_rdata=0xBEEF -> mem_addr=0x0012 held stable, mem_we=0, rf_wdata=0xBEEF to r4, total 8 cycles.
- BEQ r1,r2,-3 at PC=0x0020, r1=r2=0x0007 -> alu_control=001, alu_zero=1, next instr_addr=0x001E; same with r2=0x0008 -> 0x0021.
- JMP +1 at PC=0xFFFE -> PC=0x0000 (wrap); SLT with a=0x0002, b=0x0009 -> rf_wdata=0x0001.
- ST issued, rst asserted while mem_req=1 before mem_ack -> next cycle mem_req=0, PC=RESET_PC, instr_req=1, no rf_we.
- HALT at PC=0x0003 -> halted=1, instr_req=0 for 100 cycles regardless of instr_valid; rst clears halted.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle control and sequencing unit for the 16-bit RISC
//             core. Fetches instructions, reads the register file, drives
//             the external ALU, performs data-memory access and register
//             write-back. Instruction memory, data memory and register file
//             are external and use simple request/acknowledge handshakes.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                    clock, synchronous active-high reset
//    instr_req/instr_addr        fetch request (held until instr_valid), PC
//    instr_valid/instr_in        fetched word, accepted only in FETCH
//    rf_raddr1/rf_raddr2         register-file read addresses
//    rf_rdata1/rf_rdata2         combinational register-file read data
//    rf_we/rf_waddr/rf_wdata     one-cycle register write port
//    alu_a/alu_b/alu_control     ALU operands and function select
//    alu_result/alu_zero         ALU result and zero flag
//    mem_req/mem_we/mem_addr     data-memory request (held until mem_ack)
//    mem_wdata/mem_rdata/mem_ack store data, load data, completion
//    halted                      high after HALT until reset
// ============================================================================
module multicycle_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    // instruction memory
    output logic        instr_req,
    output logic [15:0] instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr_in,
    // register file
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    // ALU
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_control,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    // data memory
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    // status
    output logic        halted
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_fetch     = 3'd0;
    localparam logic [2:0] c_st_decode    = 3'd1;
    localparam logic [2:0] c_st_execute   = 3'd2;
    localparam logic [2:0] c_st_mem       = 3'd3;
    localparam logic [2:0] c_st_writeback = 3'd4;
    localparam logic [2:0] c_st_halted    = 3'd5;

    // Opcodes (R-type is any opcode with bit 3 clear)
    localparam logic [3:0] c_op_ld   = 4'b1000;
    localparam logic [3:0] c_op_st   = 4'b1001;
    localparam logic [3:0] c_op_beq  = 4'b1010;
    localparam logic [3:0] c_op_bne  = 4'b1011;
    localparam logic [3:0] c_op_jmp  = 4'b1100;
    localparam logic [3:0] c_op_addi = 4'b1101;
    localparam logic [3:0] c_op_nop  = 4'b1110;
    localparam logic [3:0] c_op_halt = 4'b1111;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;

    // ------------------------------------------------------------------------
    // Architectural and internal registers
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_aluout;
    logic [15:0] r_mdr;
    logic        r_instr_req;
    logic        r_mem_req;
    logic        r_rf_we;
    logic        r_halted;

    // ------------------------------------------------------------------------
    // Instruction decode (always from the latched IR)
    // ------------------------------------------------------------------------
    logic [3:0]  w_op;
    logic [15:0] w_imm6;
    logic [15:0] w_imm12;
    logic        w_is_rtype;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_addi;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_branch;
    logic        w_is_jmp;
    logic        w_is_nop;
    logic        w_is_halt;
    logic        w_use_imm;
    logic [2:0]  w_alu_sel;
    logic        w_taken;

    assign w_op        = r_ir[15:12];
    assign w_imm6      = {{10{r_ir[5]}}, r_ir[5:0]};
    assign w_imm12     = {{4{r_ir[11]}}, r_ir[11:0]};

    assign w_is_rtype  = ~w_op[3];
    assign w_is_ld     = (w_op == c_op_ld);
    assign w_is_st     = (w_op == c_op_st);
    assign w_is_addi   = (w_op == c_op_addi);
    assign w_is_beq    = (w_op == c_op_beq);
    assign w_is_bne    = (w_op == c_op_bne);
    assign w_is_branch = w_is_beq | w_is_bne;
    assign w_is_jmp    = (w_op == c_op_jmp);
    assign w_is_nop    = (w_op == c_op_nop);
    assign w_is_halt   = (w_op == c_op_halt);
    assign w_use_imm   = w_is_ld | w_is_st | w_is_addi;

    // R-type passes its opcode through; branches compare by subtraction;
    // LD/ST/ADDI (and everything else) use add.
    assign w_alu_sel   = w_is_rtype  ? w_op[2:0] :
                         w_is_branch ? c_alu_sub : c_alu_add;

    assign w_taken     = (w_is_beq & alu_zero) | (w_is_bne & ~alu_zero);

    // ------------------------------------------------------------------------
    // Register-file read addresses.
    // Branches compare rd against rs1, so rd goes on port 1 and rs1 on port 2.
    // ST needs rs1 as the address base and rd as store data (IR[5:3] is part
    // of its immediate), so rd moves to port 2.
    // ------------------------------------------------------------------------
    assign rf_raddr1 = w_is_branch ? r_ir[11:9] : r_ir[8:6];
    assign rf_raddr2 = w_is_branch ? r_ir[8:6]  :
                       w_is_st     ? r_ir[11:9] : r_ir[5:3];

    // ------------------------------------------------------------------------
    // Output drive. All values come straight from registers (or a mux of
    // registers selected by state/IR), so they stay constant across any
    // handshake wait and take their reset values one cycle after rst.
    // ------------------------------------------------------------------------
    assign instr_req   = r_instr_req;
    assign instr_addr  = r_pc;

    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_ir[11:9];
    assign rf_wdata    = w_is_ld ? r_mdr : r_aluout;

    assign alu_a       = r_a;
    assign alu_b       = ((r_state == c_st_execute) && w_use_imm) ? w_imm6 : r_b;
    assign alu_control = (r_state == c_st_execute) ? w_alu_sel : c_alu_add;

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_req & w_is_st;
    assign mem_addr    = r_aluout;
    assign mem_wdata   = r_b;

    assign halted      = r_halted;

    // ------------------------------------------------------------------------
    // Sequencer. The handshake/strobe flops are updated together with the
    // state so that they are valid from the first cycle of each state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_fetch;
            r_pc        <= RESET_PC;
            r_ir        <= 16'h0000;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_aluout    <= 16'h0000;
            r_mdr       <= 16'h0000;
            r_instr_req <= 1'b1;
            r_mem_req   <= 1'b0;
            r_rf_we     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (instr_valid) begin
                        r_ir        <= instr_in;
                        r_pc        <= r_pc + 16'd1;
                        r_instr_req <= 1'b0;
                        r_state     <= c_st_decode;
                    end
                end

                c_st_decode: begin
                    r_a <= rf_rdata1;
                    r_b <= rf_rdata2;
                    if (w_is_jmp) begin
                        // PC already points past the JMP, so this is PC+1+imm12
                        r_pc        <= r_pc + w_imm12;
                        r_instr_req <= 1'b1;
                        r_state     <= c_st_fetch;
                    end else if (w_is_nop) begin
                        r_instr_req <= 1'b1;
                        r_state     <= c_st_fetch;
                    end else if (w_is_halt) begin
                        r_halted    <= 1'b1;
                        r_state     <= c_st_halted;
                    end else begin
                        r_state     <= c_st_execute;
                    end
                end

                c_st_execute: begin
                    r_aluout <= alu_result;
                    if (w_is_branch) begin
                        if (w_taken) begin
                            r_pc <= r_pc + w_imm6;
                        end
                        r_instr_req <= 1'b1;
                        r_state     <= c_st_fetch;
                    end else if (w_is_ld || w_is_st) begin
                        r_mem_req <= 1'b1;
                        r_state   <= c_st_mem;
                    end else begin
                        r_rf_we   <= 1'b1;
                        r_state   <= c_st_writeback;
                    end
                end

                c_st_mem: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (w_is_ld) begin
                            r_mdr   <= mem_rdata;
                            r_rf_we <= 1'b1;
                            r_state <= c_st_writeback;
                        end else begin
                            r_instr_req <= 1'b1;
                            r_state     <= c_st_fetch;
                        end
                    end
                end

                c_st_writeback: begin
                    r_rf_we     <= 1'b0;
                    r_instr_req <= 1'b1;
                    r_state     <= c_st_fetch;
                end

                c_st_halted: begin
                    // terminal until reset
                    r_state <= c_st_halted;
                end

                default: begin
                    r_mem_req   <= 1'b0;
                    r_rf_we     <= 1'b0;
                    r_instr_req <= 1'b1;
                    r_state     <= c_st_fetch;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Directed self-checking bench for multicycle_ctrl. Provides
//             behavioural instruction memory, register file, ALU and data
//             memory with a programmable acknowledge delay.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic [15:0] instr_in;
    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        halted;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .halted      (halted)
    );

    // ---------------- environment models ----------------
    logic [15:0] imem [0:65535];
    logic [15:0] rf   [0:7];
    int          ack_delay   = 0;
    int          wait_cnt    = 0;
    logic        force_valid = 1'b0;

    assign instr_valid = instr_req | force_valid;
    assign instr_in    = imem[instr_addr];
    assign rf_rdata1   = rf[rf_raddr1];
    assign rf_rdata2   = rf[rf_raddr2];
    assign mem_rdata   = 16'hBEEF;
    assign mem_ack     = mem_req && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    always_comb begin
        alu_result = 16'h0000;
        case (alu_control)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = ~alu_a;
            3'b011: alu_result = alu_a << alu_b[3:0];
            3'b100: alu_result = alu_a >> alu_b[3:0];
            3'b101: alu_result = alu_a & alu_b;
            3'b110: alu_result = alu_a | alu_b;
            3'b111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 16'h0001 : 16'h0000;
            default: alu_result = 16'h0000;
        endcase
    end
    assign alu_zero = (alu_result == 16'h0000);

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; register writes land in the model just after the edge.
    task automatic step();
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        we = rf_we; wa = rf_waddr; wd = rf_wdata;
        @(posedge clk);
        #1;
        if (we) rf[wa] = wd;
    endtask

    int          cyc;
    int          we_cnt;
    logic [2:0]  we_addr;
    logic [15:0] we_data;
    logic [2:0]  exec_ctl;
    logic        exec_zero;
    logic [15:0] exec_a;
    logic [15:0] exec_b;
    int          mreq_cyc;
    logic        mem_unstable;
    logic        m_we_seen;
    logic [15:0] m_addr0;

    // Runs from a FETCH cycle until instr_req returns, recording what it saw.
    task automatic run_instr(input string tag);
        cyc = 0; we_cnt = 0; mreq_cyc = 0; mem_unstable = 1'b0; m_we_seen = 1'b0;
        we_addr = 3'd0; we_data = 16'h0; m_addr0 = 16'h0;
        do begin
            step();
            cyc++;
            if (cyc == 2) begin
                exec_ctl = alu_control; exec_zero = alu_zero;
                exec_a = alu_a; exec_b = alu_b;
            end
            if (rf_we) begin
                we_cnt++; we_addr = rf_waddr; we_data = rf_wdata;
            end
            if (mem_req) begin
                if (mreq_cyc == 0) m_addr0 = mem_addr;
                else if (mem_addr !== m_addr0) mem_unstable = 1'b1;
                m_we_seen = m_we_seen | mem_we;
                mreq_cyc++;
            end
        end while (!instr_req && cyc < 40);
        check({tag, "_refetch"}, {15'b0, instr_req}, 16'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) imem[i] = 16'hE000;   // NOP fill
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        imem[16'h0000] = 16'h0650;   // ADD r3,r1,r2
        imem[16'h0001] = 16'h8842;   // LD  r4,[r1+2]
        imem[16'h0002] = 16'hC01D;   // JMP -> 0x0020
        imem[16'h0020] = 16'hA2BD;   // BEQ r1,r2,-3
        imem[16'h001E] = 16'hC001;   // JMP -> 0x0020
        imem[16'h0021] = 16'h7BB8;   // SLT r5,r6,r7
        imem[16'h0022] = 16'hCFDB;   // JMP -> 0xFFFE
        imem[16'hFFFE] = 16'hC001;   // JMP +1 -> wraps to 0x0000
        rf[1] = 16'h0005;
        rf[2] = 16'h0003;

        // ---- reset state ----
        rst = 1'b1;
        step();
        step();
        check("rst_instr_req", {15'b0, instr_req}, 16'd1);
        check("rst_pc",        instr_addr, 16'h0000);
        check("rst_strobes",   {12'b0, rf_we, mem_req, mem_we, halted}, 16'h0000);
        check("rst_alu_ctl",   {13'b0, alu_control}, 16'h0000);
        check("rst_data",      rf_wdata | mem_addr | mem_wdata | alu_a | alu_b, 16'h0000);
        rst = 1'b0;

        // ---- ADD r3,r1,r2 ----
        run_instr("add");
        check("add_cycles", 16'(cyc), 16'd4);
        check("add_ctl",    {13'b0, exec_ctl}, 16'h0000);
        check("add_ops",    exec_a ^ 16'h0005 | exec_b ^ 16'h0003, 16'h0000);
        check("add_we_cnt", 16'(we_cnt), 16'd1);
        check("add_waddr",  {13'b0, we_addr}, 16'd3);
        check("add_wdata",  we_data, 16'h0008);
        check("add_pc",     instr_addr, 16'h0001);

        // ---- LD r4,[r1+2] with 3-cycle ack delay ----
        rf[1] = 16'h0010;
        ack_delay = 3;
        run_instr("ld");
        check("ld_cycles",   16'(cyc), 16'd8);
        check("ld_mem_addr", m_addr0, 16'h0012);
        check("ld_addr_stb", {15'b0, mem_unstable}, 16'd0);
        check("ld_req_cyc",  16'(mreq_cyc), 16'd4);
        check("ld_mem_we",   {15'b0, m_we_seen}, 16'd0);
        check("ld_waddr",    {13'b0, we_addr}, 16'd4);
        check("ld_wdata",    we_data, 16'hBEEF);
        check("ld_rf4",      rf[4], 16'hBEEF);
        ack_delay = 0;

        // ---- JMP to 0x0020 ----
        run_instr("jmp1");
        check("jmp1_cycles", 16'(cyc), 16'd2);
        check("jmp1_pc",     instr_addr, 16'h0020);

        // ---- BEQ taken ----
        rf[1] = 16'h0007;
        rf[2] = 16'h0007;
        run_instr("beq_t");
        check("beq_t_cycles", 16'(cyc), 16'd3);
        check("beq_t_ctl",    {13'b0, exec_ctl}, 16'h0001);
        check("beq_t_zero",   {15'b0, exec_zero}, 16'd1);
        check("beq_t_pc",     instr_addr, 16'h001E);

        run_instr("jmp2");
        check("jmp2_pc", instr_addr, 16'h0020);

        // ---- BEQ not taken ----
        rf[2] = 16'h0008;
        run_instr("beq_n");
        check("beq_n_zero", {15'b0, exec_zero}, 16'd0);
        check("beq_n_pc",   instr_addr, 16'h0021);

        // ---- SLT r5,r6,r7 ----
        rf[6] = 16'h0002;
        rf[7] = 16'h0009;
        run_instr("slt");
        check("slt_ctl",   {13'b0, exec_ctl}, 16'h0007);
        check("slt_waddr", {13'b0, we_addr}, 16'd5);
        check("slt_wdata", we_data, 16'h0001);

        // ---- JMP to 0xFFFE, then JMP +1 wraps ----
        run_instr("jmp3");
        check("jmp3_pc", instr_addr, 16'hFFFE);
        run_instr("jmp_wrap");
        check("wrap_cycles", 16'(cyc), 16'd2);
        check("wrap_pc",     instr_addr, 16'h0000);

        // ---- ST interrupted by reset before mem_ack ----
        rst = 1'b1;
        imem[16'h0000] = 16'h9280;   // ST r1,[r2+0]
        step();
        rst = 1'b0;
        ack_delay = 1000;
        cyc = 0;
        we_cnt = 0;
        while (!mem_req && cyc < 10) begin
            step();
            cyc++;
            if (rf_we) we_cnt++;
        end
        check("st_req_seen", {15'b0, mem_req}, 16'd1);
        check("st_mem_we",   {15'b0, mem_we}, 16'd1);
        check("st_mem_addr", mem_addr, 16'h0008);
        check("st_wdata",    mem_wdata, 16'h0007);
        step();
        step();
        check("st_req_held", {15'b0, mem_req}, 16'd1);
        rst = 1'b1;
        step();
        check("strst_mem_req",   {15'b0, mem_req}, 16'd0);
        check("strst_pc",        instr_addr, 16'h0000);
        check("strst_instr_req", {15'b0, instr_req}, 16'd1);
        check("strst_rf_we",     16'(we_cnt) | {15'b0, rf_we}, 16'd0);
        ack_delay = 0;

        // ---- HALT at PC=0x0003 ----
        imem[16'h0000] = 16'hE000;
        imem[16'h0001] = 16'hE000;
        imem[16'h0002] = 16'hE000;
        imem[16'h0003] = 16'hF000;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_instr("nop");
            check("nop_cycles", 16'(cyc), 16'd2);
        end
        check("halt_pc", instr_addr, 16'h0003);
        step();
        check("halt_dec_halted", {15'b0, halted}, 16'd0);
        step();
        check("halt_halted",    {15'b0, halted}, 16'd1);
        check("halt_instr_req", {15'b0, instr_req}, 16'd0);
        force_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check("halt_hold", {14'b0, halted, instr_req}, 16'b10);
        end
        rst = 1'b1;
        step();
        check("halt_rst_halted", {15'b0, halted}, 16'd0);
        check("halt_rst_req",    {15'b0, instr_req}, 16'd1);
        rst = 1'b0;
        force_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
